io_conditioner: RTL and testbench

Parametrised board-input conditioning and reset sequencing block for the FPGA top level. It synchronises NUM_IN asynchronous external inputs (UART RX, CTS, etc.) through a configurable-depth flop chain. It also synchronises and debounces the user button. A small state machine generates the system reset (sys_resetn): a power-on delay, hold while the button is pressed, and a re-run of the power-on delay after the button is released.

---
 rtl/io_conditioner.sv | 95 +++++++++
 tb/tb_io_conditioner.sv | 128 ++++++++++++
 2 files changed

// File: rtl/io_conditioner.sv
// io_conditioner: input synchronisers, button debounce and reset sequencer.
// Defining IO_CONDITIONER_GLITCH_FILTER_EN adds a 2-of-3 majority filter on int_out.
module io_conditioner #(
  parameter int NUM_IN = 2,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_IN-1:0] IDLE_MASK = {NUM_IN{1'b1}},
  parameter int POR_CYCLES = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              btn_n,
  input  logic [NUM_IN-1:0] ext_in,
  output logic [NUM_IN-1:0] int_out,
  output logic              btn_pressed,
  output logic              btn_event,
  output logic              sys_resetn
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(POR_CYCLES + 1);
  typedef enum logic [1:0] {POR_WAIT, RUN, HELD} state_t;
  logic [NUM_IN-1:0] in_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] btn_q;
  logic [DW-1:0] db_cnt;
  logic [PW-1:0] por_ctr;
  logic btn_raw, differ;
  state_t state;
  assign btn_raw = ~btn_q[SYNC_STAGES-1];
  assign differ = btn_raw ^ btn_pressed;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) in_q[i] <= IDLE_MASK;
      btn_q <= '1;
    end else begin
      in_q[0] <= ext_in;
      for (int i = 1; i < SYNC_STAGES; i++) in_q[i] <= in_q[i-1];
      btn_q <= {btn_q[SYNC_STAGES-2:0], btn_n};
    end
`ifdef IO_CONDITIONER_GLITCH_FILTER_EN
  logic [NUM_IN-1:0] h1, h2, s;
  assign s = in_q[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      h1 <= IDLE_MASK;
      h2 <= IDLE_MASK;
      int_out <= IDLE_MASK;
    end else begin
      h1 <= s;
      h2 <= h1;
      int_out <= (s & h1) | (s & h2) | (h1 & h2);
    end
`else
  assign int_out = in_q[SYNC_STAGES-1];
`endif
  // counter only advances while the synced level disagrees, so it never exceeds DEBOUNCE_CYCLES-1
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      db_cnt <= '0;
      btn_pressed <= 1'b0;
      btn_event <= 1'b0;
    end else begin
      btn_event <= 1'b0;
      if (!differ) db_cnt <= '0;
      else if (db_cnt >= DW'(DEBOUNCE_CYCLES - 1)) begin
        btn_pressed <= btn_raw;
        btn_event <= btn_raw;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= POR_WAIT;
      por_ctr <= PW'(POR_CYCLES);
      sys_resetn <= 1'b0;
    end else
      case (state)
        POR_WAIT:
          if (btn_pressed) state <= HELD;
          else if (por_ctr == '0) begin
            state <= RUN;
            sys_resetn <= 1'b1;
          end else por_ctr <= por_ctr - 1'b1;
        RUN:
          if (btn_pressed) begin
            state <= HELD;
            sys_resetn <= 1'b0;
          end
        HELD:
          if (!btn_pressed) begin
            state <= POR_WAIT;
            por_ctr <= PW'(POR_CYCLES);
          end
        default: state <= POR_WAIT;
      endcase
endmodule

// File: tb/tb_io_conditioner.sv
// tb_io_conditioner: directed checks of sync latency, debounce and reset sequencing.
module tb_io_conditioner;
`ifdef IO_CONDITIONER_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int LAT = 4;
`else
  localparam bit FILT = 1'b0;
  localparam int LAT = 2;
`endif
  logic clk = 1'b0, resetn, btn_n;
  logic [1:0] ext_in, int_out, int_out2;
  logic btn_pressed, btn_event, sys_resetn;
  logic btn_pressed2, btn_event2, sys_resetn2;
  int tests = 0, failed = 0, ev;
  logic stayed_low;
  always #5 clk = ~clk;
  io_conditioner dut (
    .clk(clk), .resetn(resetn), .btn_n(btn_n), .ext_in(ext_in), .int_out(int_out),
    .btn_pressed(btn_pressed), .btn_event(btn_event), .sys_resetn(sys_resetn)
  );
  io_conditioner #(.POR_CYCLES(20)) dut2 (
    .clk(clk), .resetn(resetn), .btn_n(btn_n), .ext_in(ext_in), .int_out(int_out2),
    .btn_pressed(btn_pressed2), .btn_event(btn_event2), .sys_resetn(sys_resetn2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    resetn = 1'b0;
    btn_n = 1'b1;
    ext_in = 2'b11;
    repeat (2) @(negedge clk);
    check("rst_int_out", int_out, 2'b11);
    check("rst_btn", {btn_pressed, btn_event}, 2'b00);
    check("rst_sys", sys_resetn, 1'b0);
    check("rst_sys2", sys_resetn2, 1'b0);
    resetn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick;
      check("por_sys", sys_resetn, i == 4);
      check("por_int_out", int_out, 2'b11);
    end
    ext_in = 2'b10;
    for (int k = 1; k <= LAT; k++) begin
      tick;
      check("lat_fall", int_out, k == LAT ? 2'b10 : 2'b11);
    end
    ext_in = 2'b11;
    repeat (LAT) tick;
    check("lat_rise", int_out, 2'b11);
    ext_in = 2'b10;
    tick;
    ext_in = 2'b11;
    for (int k = 2; k <= LAT + 3; k++) begin
      tick;
      check("pulse", int_out, (!FILT && k == LAT) ? 2'b10 : 2'b11);
    end
    for (int i = 0; i < 40; i++) begin
      btn_n = (i < 10) ? 1'b0 : 1'b1;
      tick;
      check("glitch", {btn_pressed, btn_event, sys_resetn}, 3'b001);
    end
    ev = 0;
    btn_n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick;
      ev += int'(btn_event);
      if (i == 17) check("press_early", {btn_pressed, sys_resetn}, 2'b01);
      if (i == 18) check("press_edge", {btn_pressed, btn_event, sys_resetn}, 3'b111);
      if (i == 19) check("press_sys", {btn_pressed, btn_event, sys_resetn}, 3'b100);
    end
    check("press_events", ev, 1);
    btn_n = 1'b1;
    for (int i = 1; i <= 23; i++) begin
      tick;
      if (i == 17) check("rel_early", btn_pressed, 1'b1);
      if (i == 18) check("rel_edge", {btn_pressed, btn_event}, 2'b00);
      if (i >= 19 && i <= 22) check("rel_sys_low", sys_resetn, 1'b0);
      if (i == 23) check("rel_sys_high", sys_resetn, 1'b1);
    end
    resetn = 1'b0;
    btn_n = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    stayed_low = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick;
      if (sys_resetn2) stayed_low = 1'b0;
      if (i == 4) check("porp_short_sys", sys_resetn, 1'b1);
      if (i == 18) check("porp_pressed", btn_pressed2, 1'b1);
      if (i == 19) check("porp_short_held", sys_resetn, 1'b0);
    end
    check("porp_held", stayed_low, 1'b1);
    btn_n = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick;
      if (i < 40 && sys_resetn2) stayed_low = 1'b0;
      if (i == 18) check("porp_rel", btn_pressed2, 1'b0);
      if (i == 40) check("porp_sys_high", sys_resetn2, 1'b1);
    end
    check("porp_wait", stayed_low, 1'b1);
    ext_in = 2'b01;
    repeat (LAT + 1) tick;
    check("pre_rst_int_out", int_out, 2'b01);
    btn_n = 1'b0;
    repeat (10) tick;
    check("pre_rst_sys", {btn_pressed, sys_resetn}, 2'b01);
    resetn = 1'b0;
    #1;
    check("async_int_out", int_out, 2'b11);
    check("async_int_out2", int_out2, 2'b11);
    check("async_btn", {btn_pressed, btn_event, sys_resetn}, 3'b000);
    check("async_btn2", {btn_pressed2, btn_event2, sys_resetn2}, 3'b000);
    resetn = 1'b1;
    btn_n = 1'b1;
    repeat (3) tick;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
